// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM modulator / demodulator pair.
package pdm_pkg;

    // Default output resolution and window size shared by both ends of the link
    localparam int unsigned PDM_N        = 16;
    localparam int unsigned PDM_LOG2_WIN = 8;

    // Map a window ones-count (0..2^log2_win) onto an n-bit level.
    // A completely full window saturates to all-ones instead of overflowing.
    function automatic logic [31:0] scale_level(
        input logic [31:0] total,
        input int unsigned n,
        input int unsigned log2_win
    );
        logic [31:0] full;
        full = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
        if (total == (32'd1 << log2_win)) begin
            return full;
        end
        return total << (n - log2_win);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of an asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pdm_demod.sv
// Pulse-density demodulator: counts ones over a 2^LOG2_WIN sample window
// and presents the scaled level on a valid/ready output.
module pdm_demod
    import pdm_pkg::*;
#(
    parameter int unsigned N        = PDM_N,
    parameter int unsigned LOG2_WIN = PDM_LOG2_WIN,
    parameter int unsigned DIV      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         pdm_in,
    output logic [N-1:0] level,
    output logic         valid,
    input  logic         ready,
    output logic         overrun
);

    localparam int unsigned WIN   = 1 << LOG2_WIN;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned ACC_W = LOG2_WIN + 1;

    logic                bit_s;
    logic [1:0]          warm;
    logic [DIV_W-1:0]    div_cnt;
    logic [LOG2_WIN-1:0] samp_cnt;
    logic [ACC_W-1:0]    acc;
    logic                tick_c;
    logic                win_end_c;
    logic [ACC_W-1:0]    total_c;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pdm_in),
        .q   (bit_s)
    );

    // Sampling waits until the synchronizer holds real input rather than reset zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm <= 2'b00;
        end else begin
            warm <= {warm[0], 1'b1};
        end
    end

    // Tick and window-end decode plus the running total including the current bit
    always_comb begin
        tick_c    = warm[1] && (div_cnt == DIV_W'(DIV - 1));
        win_end_c = tick_c && (samp_cnt == LOG2_WIN'(WIN - 1));
        total_c   = acc + ACC_W'(bit_s);
    end

    // Sample-rate divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
        end else if (warm[1]) begin
            div_cnt <= (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Window sample counter and ones accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt <= '0;
            acc      <= '0;
        end else if (clear) begin
            samp_cnt <= '0;
            acc      <= '0;
        end else if (tick_c) begin
            samp_cnt <= samp_cnt + LOG2_WIN'(1);
            acc      <= win_end_c ? '0 : total_c;
        end
    end

    // Output register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (clear) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (win_end_c) begin
            level <= N'(scale_level(32'(total_c), N, LOG2_WIN));
            valid <= 1'b1;
            if (valid && !ready) begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: doc/pdm_demod.md
Name: pdm_demod

Overview:
- Recovers an N-bit level from a 1-bit pulse-density stream. It is the receive-side counterpart to the team's PDM modulator.
- Samples the stream at a programmable rate and counts ones over a fixed window of 2^LOG2_WIN samples. It scales the count to N bits and presents it on a valid/ready output.
- Uses: loopback self-test of the PDM LED path, and reading external PDM sources such as comparator outputs and sigma-delta sensors.

Parameters:
- N, 16: output level resolution in bits.
- LOG2_WIN, 8: log2 of the window length in samples. Requires 1 <= LOG2_WIN <= N.
- DIV, 1: clock cycles per sample, DIV >= 1. DIV=1 samples every clock.

Ports:
- clk  in  1  system clock. All state is clocked on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart: flushes the window and drops pending output.
- pdm_in  in  1  pulse-density input. May be asynchronous to clk.
- level  out  N  recovered level. 0 = never on, all-ones = always on.
- valid  out  1  level holds an unconsumed result.
- ready  in  1  consumer accepts level on a cycle where valid & ready.
- overrun  out  1  sticky flag: a result was overwritten before it was consumed.

Behaviour:
- Reset (rst=1, asynchronous): level=0, valid=0, overrun=0. The synchronizer, divider count, sample count and ones accumulator all clear. Effect is immediate on assertion; counting resumes on the first clk edge after deassertion.
- Synchronizer: 2-flop synchronizer on pdm_in. The sampled bit is the 2nd-stage output, giving 2 cycles of input latency.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps to 0.
  - tick = (div_cnt == DIV-1). When DIV=1, tick is constantly 1.
- Sampling, on each tick:
  - acc <= acc + bit. acc is LOG2_WIN+1 bits wide.
  - samp_cnt <= samp_cnt + 1, LOG2_WIN bits wide, wrapping naturally.
- Window end (tick with samp_cnt == 2^LOG2_WIN - 1):
  - total = acc + bit, range 0..2^LOG2_WIN.
  - level <= total << (N - LOG2_WIN), except total == 2^LOG2_WIN, which saturates to all-ones.
  - acc <= 0 and samp_cnt wraps to 0.
  - valid <= 1, visible the cycle after the final tick.
- Handshake:
  - valid & ready: the result is consumed and valid <= 0, unless a new result loads in the same cycle.
  - New result while valid & ~ready: level is overwritten, valid stays 1, overrun <= 1.
  - New result while valid & ready: the old result counts as consumed, the new one loads, valid stays 1, no overrun.
  - level is stable whenever valid=1 and no new result loads.
- overrun: sticky; cleared only by rst or clear.
- clear=1 (synchronous, highest priority after rst):
  - acc, samp_cnt and div_cnt go to 0; valid and overrun go to 0; level retains its value.
  - The synchronizer is not flushed.
  - The next window starts at the first tick after clear deasserts.
- Latency: the first result appears 2 + DIV*2^LOG2_WIN cycles after the stream starts. Defaults: 258 cycles.
- No back-pressure on sampling: the window always runs, and results are lost (flagged by overrun) if not consumed.

Decomposition:
- Shared package pdm_pkg: function scale_level(total) implementing the shift/saturate rule. Also a localparam WIN = 1 << LOG2_WIN convention for modulator and demodulator.
- One natural sub-module, sync2: a 2-flop synchronizer with asynchronous reset, reusable elsewhere.
- Divider, window counter and output stage stay inline.

Test Plan:
- N=16, LOG2_WIN=8, DIV=1, pdm_in held 1: first valid at cycle 258 after rst release, level=16'hFFFF. pdm_in held 0: level=16'h0000.
- Alternating 1,0 stream: level=16'h8000 on every window, valid each 256 cycles when ready=1.
- Loopback from the PDM modulator with modulator level 16'h4000, ignoring the first window: level=16'h4000 exactly on every subsequent window.
- ready=0 across two window ends:
  - after 1st end: valid=1, overrun=0.
  - after 2nd end: overrun=1, level = 2nd window's value.
  - ready=1 for one cycle: valid=0, overrun stays 1 until clear.
- DIV=4, constant 1: first valid at 2 + 1024 cycles, level=16'hFFFF. ready pulsed on the exact cycle the next result loads: valid stays 1, no overrun.
- rst asserted asynchronously mid-window, e.g. sample 100: level, valid and overrun go to 0 before the next clk edge. With pdm_in held 1 from before rst release, the next valid arrives 258 cycles after release with a full-window result.
